// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: deserialises WIDTH data bits plus one parity bit per frame,
// flags parity errors per frame and keeps a saturating count of bad frames.
module parity_frame_checker #(
  parameter int unsigned WIDTH = 8,
  parameter bit          ODD   = 1'b0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  output logic             out,
  output logic [WIDTH-1:0] data,
  output logic             frame_valid,
  output logic             par_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned      IdxW    = $clog2(WIDTH + 1);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(WIDTH);

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fv_q, fv_d;
  logic             perr_q, perr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    idx_d  = idx_q;
    sh_d   = sh_q;
    acc_d  = acc_q;
    data_d = data_q;
    fv_d   = 1'b0;
    perr_d = perr_q;
    cnt_d  = cnt_q;
    if (in_valid) begin
      if (idx_q == LastIdx) begin
        // Parity phase: publish the word and restart the frame.
        data_d = sh_q;
        perr_d = (in != (acc_q ^ ODD));
        fv_d   = 1'b1;
        if (perr_d && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        idx_d = '0;
        acc_d = 1'b0;
      end else begin
        // Shift-then-insert also covers WIDTH == 1 without a zero-width slice.
        sh_d    = sh_q << 1;
        sh_d[0] = in;
        acc_d   = acc_q ^ in;
        idx_d   = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      sh_q   <= '0;
      acc_q  <= 1'b0;
      data_q <= '0;
      fv_q   <= 1'b0;
      perr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      data_q <= data_d;
      fv_q   <= fv_d;
      perr_q <= perr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = acc_q ^ ODD;
  assign data        = data_q;
  assign frame_valid = fv_q;
  assign par_err     = perr_q;
  assign err_count   = cnt_q;

endmodule
